// File: rtl/seg7_pkg.sv
// seg7_pkg: BCD digit types and constants shared by the counter and the 7-segment decoder.
package seg7_pkg;
   localparam int         BCD_W    = 4;
   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_ZERO = 4'd0;

   typedef logic [BCD_W-1:0] bcd_t;

   // Non-decimal nibbles from the switches collapse to zero so q stays valid BCD.
   function automatic bcd_t bcd_sanitize(input bcd_t v);
      return (v > BCD_MAX) ? BCD_ZERO : v;
   endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decade of the counter; wrap feeds the carry/borrow chain into the next digit.
module bcd_digit
   import seg7_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic ld,
   input  bcd_t ld_val,
   input  logic clr,
   input  logic step,
   input  logic up,
   output bcd_t q,
   output logic wrap
);
   bcd_t q_q, q_d, inc, dec;

   assign inc  = (q_q == BCD_MAX)  ? BCD_ZERO : q_q + 4'd1;
   assign dec  = (q_q == BCD_ZERO) ? BCD_MAX  : q_q - 4'd1;
   assign wrap = step & (up ? (q_q == BCD_MAX) : (q_q == BCD_ZERO));
   assign q_d  = clr ? BCD_ZERO : ld ? ld_val : step ? (up ? inc : dec) : q_q;
   assign q    = q_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_q <= BCD_ZERO;
      else        q_q <= q_d;
   end
endmodule

// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: prescaled multi-digit BCD up/down counter with synchronized switch controls.
module bcd_tick_counter
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 2,
   parameter int TICK_DIV    = 100000000,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    up,
   input  logic                    load,
   input  logic                    clr,
   input  logic [4*NUM_DIGITS-1:0] d,
   output logic [4*NUM_DIGITS-1:0] q,
   output logic                    co,
   output logic                    tick
);
   localparam int CW = $clog2(TICK_DIV);

   logic [SYNC_STAGES-1:0] en_q, up_q, ld_q, clr_q;
   logic                   en_s, up_s, ld_s, clr_s;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   co_q, co_d;
   logic [NUM_DIGITS:0]    carry;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q  <= '0;
         up_q  <= '0;
         ld_q  <= '0;
         clr_q <= '0;
         cnt_q <= '0;
         co_q  <= 1'b0;
      end else begin
         en_q  <= {en_q[SYNC_STAGES-2:0], en};
         up_q  <= {up_q[SYNC_STAGES-2:0], up};
         ld_q  <= {ld_q[SYNC_STAGES-2:0], load};
         clr_q <= {clr_q[SYNC_STAGES-2:0], clr};
         cnt_q <= cnt_d;
         co_q  <= co_d;
      end
   end

   assign en_s  = en_q[SYNC_STAGES-1];
   assign up_s  = up_q[SYNC_STAGES-1];
   assign ld_s  = ld_q[SYNC_STAGES-1];
   assign clr_s = clr_q[SYNC_STAGES-1];

   // Clear and load restart the prescaler so the first count after release gets a full period.
   assign tick  = (cnt_q == CW'(TICK_DIV - 1));
   assign cnt_d = (clr_s || ld_s || tick) ? '0 : cnt_q + CW'(1);

   // carry[i] steps digit i; the last carry marks a full-range wrap.
   assign carry[0] = tick & en_s;
   assign co_d     = carry[NUM_DIGITS] & ~clr_s & ~ld_s;
   assign co       = co_q;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk   (clk),
         .rst_n (rst_n),
         .ld    (ld_s),
         .ld_val(bcd_sanitize(d[BCD_W*i +: BCD_W])),
         .clr   (clr_s),
         .step  (carry[i]),
         .up    (up_s),
         .q     (q[BCD_W*i +: BCD_W]),
         .wrap  (carry[i+1])
      );
   end
endmodule
